// File: rtl/mac_lane_engine.sv
// Multi-lane MAC engine: LANES output channels share one activation stream,
// each accumulating KERNEL_LEN taps onto a bias and requantising to N bits.
module mac_lane_engine #(
    parameter int N          = 8,
    parameter int LANES      = 4,
    parameter int KERNEL_LEN = 3,
    parameter int ACC_W      = 2*N+4,
    parameter int BIAS_W     = 2*N,
    parameter int SHIFT      = 2,
    localparam int CW        = $clog2(KERNEL_LEN)+1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            x_in,
    input  logic [LANES*N-1:0]      w_in,
    input  logic [LANES*BIAS_W-1:0] bias_in,
    input  logic                    relu_en,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*N-1:0]      out_data,
    output logic [CW-1:0]           tap_cnt
);

    typedef enum logic [0:0] {ACCUM, OUT} state_t;

    localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'((2**SHIFT)/2);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(N-1)-1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(N-1)));

    state_t state, state_next;
    logic   accept, first_tap, last_tap, relu_q, relu_sel;

    logic signed [ACC_W-1:0] acc    [LANES];
    logic signed [ACC_W-1:0] sum_p0 [LANES];
    logic signed [N-1:0]     res_p0 [LANES];
    logic [LANES*N-1:0]      out_p1;

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0] base,
        input logic signed [N-1:0]     x,
        input logic signed [N-1:0]     w
    );
        logic signed [2*N-1:0] prod;
        prod = (2*N)'(x) * (2*N)'(w);
        return base + ACC_W'(prod);
    endfunction

    // One extra bit of headroom so the rounding add never wraps.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] wide;
        wide = (ACC_W+1)'(a) + RND;
        return wide >>> SHIFT;
    endfunction

    function automatic logic signed [N-1:0] saturate(
        input logic signed [ACC_W:0] r,
        input logic                  relu
    );
        logic signed [ACC_W:0] v;
        v = (relu && r[ACC_W]) ? '0 : r;
        if (v > SAT_MAX)
            return SAT_MAX[N-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[N-1:0];
        else
            return v[N-1:0];
    endfunction

    assign first_tap = (tap_cnt == '0);
    assign last_tap  = (tap_cnt == CW'(KERNEL_LEN-1));
    assign relu_sel  = first_tap ? relu_en : relu_q;
    assign out_data  = out_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            tap_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ACCUM && flush)
                tap_cnt <= '0;
            else if (accept)
                tap_cnt <= last_tap ? '0 : tap_cnt + CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = !flush;
                accept   = in_valid && !flush;
                if (accept && last_tap)
                    state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    // p0: per-lane MAC onto bias or running sum, then requantise
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sum_p0[i] = mac(first_tap ? ACC_W'(signed'(bias_in[i*BIAS_W +: BIAS_W])) : acc[i],
                            signed'(x_in), signed'(w_in[i*N +: N]));
            res_p0[i] = saturate(round_shift(sum_p0[i]), relu_sel);
        end
    end

    // p1: running sums and the finished window
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++)
                acc[i] <= '0;
            out_p1 <= '0;
            relu_q <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++)
                acc[i] <= sum_p0[i];
            if (first_tap)
                relu_q <= relu_en;
            if (last_tap)
                for (int i = 0; i < LANES; i++)
                    out_p1[i*N +: N] <= res_p0[i];
        end
    end

endmodule
